// File: rtl/axi_default_slave.sv
// Default (error) slave for the AXI interconnect.
// It accepts every transaction routed to it, discards any write data, and
// answers with DECERR. The read and write paths are independent and each
// holds at most one transaction. Every output comes straight from a register.

module axi_default_slave #(
    parameter int unsigned WIDTH_CID   = 4,
    parameter int unsigned WIDTH_ID    = 4,
    parameter int unsigned WIDTH_AD    = 32,
    parameter int unsigned WIDTH_DA    = 32,
    parameter int unsigned WIDTH_DS    = WIDTH_DA / 8,
    parameter int unsigned WIDTH_SID   = WIDTH_CID + WIDTH_ID,
    parameter int unsigned WIDTH_BUSER = 1,
    parameter int unsigned WIDTH_RUSER = 1
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    // Write address channel
    input  logic [WIDTH_SID-1:0]   AWID,
    input  logic [WIDTH_AD-1:0]    AWADDR,
    input  logic [3:0]             AWLEN,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    // Write data channel
    input  logic [WIDTH_SID-1:0]   WID,
    input  logic [WIDTH_DA-1:0]    WDATA,
    input  logic [WIDTH_DS-1:0]    WSTRB,
    input  logic                   WLAST,
    input  logic                   WVALID,
    output logic                   WREADY,
    // Write response channel
    output logic [WIDTH_SID-1:0]   BID,
    output logic [1:0]             BRESP,
    output logic                   BVALID,
    input  logic                   BREADY,
`ifdef AMBA_AXI_BUSER
    output logic [WIDTH_BUSER-1:0] BUSER,
`endif
    // Read address channel
    input  logic [WIDTH_SID-1:0]   ARID,
    input  logic [WIDTH_AD-1:0]    ARADDR,
    input  logic [3:0]             ARLEN,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    // Read data channel
    output logic [WIDTH_SID-1:0]   RID,
    output logic [WIDTH_DA-1:0]    RDATA,
    output logic [1:0]             RRESP,
    output logic                   RLAST,
    output logic                   RVALID,
`ifdef AMBA_AXI_RUSER
    output logic [WIDTH_RUSER-1:0] RUSER,
`endif
    input  logic                   RREADY
);

    localparam logic [1:0] RespDecErr = 2'b11;
    localparam logic [1:0] RespOkay   = 2'b00;

    typedef enum logic [1:0] {
        WIdle = 2'b00,
        WData = 2'b01,
        WResp = 2'b10
    } w_state_e;

    typedef enum logic [0:0] {
        RIdle = 1'b0,
        RData = 1'b1
    } r_state_e;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_e             w_state_q, w_state_d;
    logic [WIDTH_SID-1:0] bid_q, bid_d;
    logic                 awready_q, awready_d;
    logic                 wready_q, wready_d;
    logic                 bvalid_q, bvalid_d;
    logic [1:0]           bresp_q, bresp_d;

    // Write FSM next state; the handshake strobes use the registered readies
    // so that nothing is accepted during the first cycle after reset.
    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        case (w_state_q)
            WIdle: begin
                if (AWVALID && awready_q) begin
                    bid_d     = AWID;
                    w_state_d = WData;
                end
            end
            WData: begin
                // Burst length comes from WLAST; AWLEN is not trusted.
                if (WVALID && wready_q && WLAST) begin
                    w_state_d = WResp;
                end
            end
            WResp: begin
                if (BREADY && bvalid_q) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
        awready_d = (w_state_d == WIdle);
        wready_d  = (w_state_d == WData);
        bvalid_d  = (w_state_d == WResp);
        bresp_d   = bvalid_d ? RespDecErr : RespOkay;
    end

    // Write state and registered write-channel outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= WIdle;
            bid_q     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
        end else begin
            w_state_q <= w_state_d;
            bid_q     <= bid_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_e             r_state_q, r_state_d;
    logic [WIDTH_SID-1:0] rid_q, rid_d;
    logic [3:0]           rlen_q, rlen_d;
    logic [3:0]           rcnt_q, rcnt_d;
    logic                 arready_q, arready_d;
    logic                 rvalid_q, rvalid_d;
    logic                 rlast_q, rlast_d;
    logic [1:0]           rresp_q, rresp_d;

    // Read FSM next state; one beat per accepted RREADY until ARLEN+1 beats.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        case (r_state_q)
            RIdle: begin
                if (ARVALID && arready_q) begin
                    rid_d     = ARID;
                    rlen_d    = ARLEN;
                    rcnt_d    = '0;
                    r_state_d = RData;
                end
            end
            RData: begin
                if (RREADY && rvalid_q) begin
                    if (rlast_q) begin
                        r_state_d = RIdle;
                    end else begin
                        // Cannot wrap: rlast_q stops the count at rlen_q <= 15.
                        rcnt_d = rcnt_q + 4'd1;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
        arready_d = (r_state_d == RIdle);
        rvalid_d  = (r_state_d == RData);
        rlast_d   = rvalid_d && (rcnt_d == rlen_d);
        rresp_d   = rvalid_d ? RespDecErr : RespOkay;
    end

    // Read state and registered read-channel outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= RIdle;
            rid_q     <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RespOkay;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RLAST   = rlast_q;
    assign RRESP   = rresp_q;
    assign RDATA   = '0;

    // ------------------------------------------------------------------
    // User sidebands and deliberately ignored inputs
    // ------------------------------------------------------------------
`ifdef AMBA_AXI_BUSER
    assign BUSER = '0;
`else
    logic [WIDTH_BUSER-1:0] unused_buser;
    assign unused_buser = '0;
`endif

`ifdef AMBA_AXI_RUSER
    assign RUSER = '0;
`else
    logic [WIDTH_RUSER-1:0] unused_ruser;
    assign unused_ruser = '0;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{AWADDR, AWLEN, WID, WDATA, WSTRB, ARADDR};

endmodule

// File: tb/tb_axi_default_slave.sv
// Bench for axi_default_slave: directed traffic, expected B/R responses
// queued at issue time and checked by a separate handshake monitor.

module tb_axi_default_slave;

    localparam int SIDW = 8;
    localparam int ADW  = 32;
    localparam int DAW  = 32;

    logic            ACLK;
    logic            ARESETn;
    logic [SIDW-1:0] AWID;
    logic [ADW-1:0]  AWADDR;
    logic [3:0]      AWLEN;
    logic            AWVALID;
    logic            AWREADY;
    logic [SIDW-1:0] WID;
    logic [DAW-1:0]  WDATA;
    logic [3:0]      WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;
    logic [SIDW-1:0] BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
`ifdef AMBA_AXI_BUSER
    logic [0:0]      BUSER;
`endif
    logic [SIDW-1:0] ARID;
    logic [ADW-1:0]  ARADDR;
    logic [3:0]      ARLEN;
    logic            ARVALID;
    logic            ARREADY;
    logic [SIDW-1:0] RID;
    logic [DAW-1:0]  RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;
`ifdef AMBA_AXI_RUSER
    logic [0:0]      RUSER;
`endif

    axi_default_slave dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .AWID    (AWID),
        .AWADDR  (AWADDR),
        .AWLEN   (AWLEN),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WID     (WID),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WLAST   (WLAST),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BID     (BID),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
`ifdef AMBA_AXI_BUSER
        .BUSER   (BUSER),
`endif
        .ARID    (ARID),
        .ARADDR  (ARADDR),
        .ARLEN   (ARLEN),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RID     (RID),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RLAST   (RLAST),
        .RVALID  (RVALID),
`ifdef AMBA_AXI_RUSER
        .RUSER   (RUSER),
`endif
        .RREADY  (RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [SIDW-1:0] id;
        logic [1:0]      resp;
    } b_exp_t;

    typedef struct packed {
        logic [SIDW-1:0] id;
        logic [DAW-1:0]  data;
        logic [1:0]      resp;
        logic            last;
    } r_exp_t;

    b_exp_t b_q[$];
    r_exp_t r_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Inputs change only 1 time unit after the rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Monitor: at the falling edge the inputs for the coming edge are stable,
    // so a valid&ready pair seen here is a handshake at the next rising edge.
    logic   b_hold_v = 1'b0;
    b_exp_t b_hold;
    logic   r_hold_v = 1'b0;
    r_exp_t r_hold;

    always @(negedge ACLK) begin
        b_exp_t be;
        r_exp_t re;
        if (!ARESETn) begin
            b_hold_v = 1'b0;
            r_hold_v = 1'b0;
        end else begin
            if (b_hold_v) begin
                chk("b_stall_valid", 64'(BVALID), 64'd1);
                chk("b_stall_payload", 64'({BID, BRESP}), 64'(b_hold));
            end
            if (r_hold_v) begin
                chk("r_stall_valid", 64'(RVALID), 64'd1);
                chk("r_stall_payload", 64'({RID, RDATA, RRESP, RLAST}), 64'(r_hold));
            end
            b_hold_v = BVALID && !BREADY;
            b_hold   = {BID, BRESP};
            r_hold_v = RVALID && !RREADY;
            r_hold   = {RID, RDATA, RRESP, RLAST};

            if (BVALID && BREADY) begin
                if (b_q.size() == 0) begin
                    fail_now("b_unexpected");
                end else begin
                    be = b_q.pop_front();
                    chk("b_beat", 64'({BID, BRESP}), 64'(be));
                end
            end
            if (RVALID && RREADY) begin
                if (r_q.size() == 0) begin
                    fail_now("r_unexpected");
                end else begin
                    re = r_q.pop_front();
                    chk("r_beat", 64'({RID, RDATA, RRESP, RLAST}), 64'(re));
                end
            end
        end
    end

    // Full write: AW, n beats, then B held off for 'hold' cycles.
    task automatic do_write(input logic [SIDW-1:0] id, input int n, input int hold);
        BREADY  = (hold == 0);
        AWVALID = 1'b1;
        AWID    = id;
        AWADDR  = $urandom;
        AWLEN   = 4'(n - 1);
        for (int i = 0; i < 50 && !AWREADY; i++) tick();
        chk("aw_ready", 64'(AWREADY), 64'd1);
        if (AWREADY) b_q.push_back('{id: id, resp: 2'b11});
        tick();
        AWVALID = 1'b0;
        chk("w_ready_after_aw", 64'(WREADY), 64'd1);
        for (int i = 0; i < n; i++) begin
            WVALID = 1'b1;
            WLAST  = (i == n - 1);
            WDATA  = $urandom;
            WSTRB  = 4'($urandom);
            for (int j = 0; j < 50 && !WREADY; j++) tick();
            chk("w_ready_beat", 64'(WREADY), 64'd1);
            tick();
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        chk("b_valid_after_wlast", 64'({BVALID, BID, BRESP}), 64'({1'b1, id, 2'b11}));
        if (hold > 0) begin
            repeat (hold) tick();
            chk("b_held", 64'({BVALID, BID}), 64'({1'b1, id}));
            BREADY = 1'b1;
        end
        tick();
        BREADY = 1'b0;
        chk("aw_ready_after_b", 64'({AWREADY, BVALID}), 64'({1'b1, 1'b0}));
    endtask

    // Full read of len+1 beats; 'toggle' makes RREADY alternate 1,0,1,0...
    task automatic do_read(input logic [SIDW-1:0] id, input logic [3:0] len, input bit toggle);
        int beats;
        int cyc;
        ARVALID = 1'b1;
        ARID    = id;
        ARLEN   = len;
        ARADDR  = $urandom;
        for (int i = 0; i < 50 && !ARREADY; i++) tick();
        chk("ar_ready", 64'(ARREADY), 64'd1);
        if (ARREADY) begin
            for (int i = 0; i <= int'(len); i++) begin
                r_q.push_back('{id: id, data: '0, resp: 2'b11, last: (i == int'(len))});
            end
        end
        tick();
        ARVALID = 1'b0;
        chk("r_valid_after_ar", 64'(RVALID), 64'd1);
        beats = 0;
        cyc   = 0;
        while (beats <= int'(len) && cyc < 100) begin
            RREADY = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (RVALID && RREADY) beats++;
            tick();
            cyc++;
        end
        RREADY = 1'b0;
        chk("r_beat_count", 64'(beats), 64'(int'(len) + 1));
        chk("ar_ready_after_last", 64'({ARREADY, RVALID}), 64'({1'b1, 1'b0}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1'b0;
        {AWID, AWADDR, AWLEN, AWVALID, WID, WDATA, WSTRB, WLAST, WVALID, BREADY} = '0;
        {ARID, ARADDR, ARLEN, ARVALID, RREADY} = '0;

        // Reset with random input activity: every output must stay low.
        for (int i = 0; i < 4; i++) begin
            AWID = 8'($urandom); AWADDR = $urandom; AWLEN = 4'($urandom);
            AWVALID = 1'($urandom); WID = 8'($urandom); WDATA = $urandom;
            WSTRB = 4'($urandom); WLAST = 1'($urandom); WVALID = 1'($urandom);
            BREADY = 1'($urandom); ARID = 8'($urandom); ARADDR = $urandom;
            ARLEN = 4'($urandom); ARVALID = 1'($urandom); RREADY = 1'($urandom);
            tick();
            chk("reset_outputs",
                64'({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, BID, RID, BRESP, RRESP,
                     RDATA}), 64'd0);
        end
        {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY} = '0;
        ARESETn = 1'b1;
        tick();
        chk("ready_after_reset", 64'({AWREADY, ARREADY}), 64'b11);

        // W beats without an accepted AW must stall.
        WVALID = 1'b1;
        WLAST  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("w_stall_no_aw", 64'({WREADY, BVALID}), 64'd0);
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;

        do_write(8'h35, 4, 0);
        do_read(8'h21, 4'd3, 1'b0);

        // Backpressure on both response channels.
        do_read(8'h5a, 4'd15, 1'b1);
        do_write(8'h7c, 2, 5);

        // AW and AR issued in the same cycle.
        chk("both_ready_idle", 64'({AWREADY, ARREADY}), 64'b11);
        fork
            do_write(8'h11, 1, 0);
            do_read(8'h12, 4'd0, 1'b0);
        join

        // Asynchronous reset during the second beat of an 8-beat read.
        ARVALID = 1'b1;
        ARID    = 8'h33;
        ARLEN   = 4'd7;
        chk("ar_ready_pre_reset", 64'(ARREADY), 64'd1);
        r_q.push_back('{id: 8'h33, data: '0, resp: 2'b11, last: 1'b0});
        tick();
        ARVALID = 1'b0;
        RREADY  = 1'b1;
        tick();
        RREADY  = 1'b0;
        chk("beat2_presented", 64'({RVALID, RLAST}), 64'({1'b1, 1'b0}));
        ARESETn = 1'b0;
        #1;
        chk("mid_read_reset", 64'({RVALID, RLAST, ARREADY, RID, RRESP}), 64'd0);
        tick();
        ARESETn = 1'b1;
        tick();
        chk("ar_ready_after_rst", 64'(ARREADY), 64'd1);
        do_read(8'h44, 4'd0, 1'b0);

        repeat (3) tick();
        chk("b_queue_drained", 64'(b_q.size()), 64'd0);
        chk("r_queue_drained", 64'(r_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_default_slave.md
Name: axi_default_slave

Overview:
- Default (error) slave of the AXI interconnect. It claims every transaction whose address decodes to no real slave.
- It consumes each such transaction fully and answers it with DECERR responses.
- Its B and R channels feed the SD_* inputs of each per-master response mux, so its IDs carry the widened slave-side ID: master channel ID in the upper bits, original ID in the lower bits.
- Read and write paths are independent, one outstanding transaction each.

Parameters:
- WIDTH_CID, 4, channel (master) ID width in bits
- WIDTH_ID, 4, transaction ID width in bits
- WIDTH_AD, 32, address width
- WIDTH_DA, 32, data width
- WIDTH_DS, WIDTH_DA/8, write-strobe width
- WIDTH_SID, WIDTH_CID+WIDTH_ID, slave-side ID width
- WIDTH_BUSER, 1, B user width (port present only when AMBA_AXI_BUSER is defined)
- WIDTH_RUSER, 1, R user width (port present only when AMBA_AXI_RUSER is defined)

Ports:
- ACLK  in  1  clock, rising edge
- ARESETn  in  1  reset; one clock; asynchronous, active-low
- AWID  in  WIDTH_SID  write address ID
- AWADDR  in  WIDTH_AD  ignored
- AWLEN  in  4  ignored; write length is taken from WLAST
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WID  in  WIDTH_SID  ignored
- WDATA  in  WIDTH_DA  ignored
- WSTRB  in  WIDTH_DS  ignored
- WLAST  in  1  last write beat
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BID  out  WIDTH_SID  response ID
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- BUSER  out  WIDTH_BUSER  constant 0
- ARID  in  WIDTH_SID  read address ID
- ARADDR  in  WIDTH_AD  ignored
- ARLEN  in  4  burst length minus 1
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RID  out  WIDTH_SID  read ID
- RDATA  out  WIDTH_DA  read data, always 0
- RRESP  out  2  read response
- RLAST  out  1  last read beat
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- RUSER  out  WIDTH_RUSER  constant 0

Behaviour:
- All outputs are decoded from registers only; there is no combinational input-to-output path.

Reset (any time, including mid-burst):
- Both FSMs return to IDLE.
- In-flight transactions are abandoned.
- Output values in reset: AWREADY=0, ARREADY=0, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BID=0, RID=0, BRESP=0, RRESP=0, RDATA=0.
- First cycle after reset release: AWREADY=1, ARREADY=1.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: AWREADY=1. On AWVALID, latch AWID and go to W_DATA.
- W_DATA: WREADY=1. Every WVALID beat is discarded. On WVALID&WLAST, go to W_RESP.
- W_RESP: BVALID=1, BID=latched AWID, BRESP=2'b11 (DECERR). Hold all of these stable until BREADY, then go to W_IDLE.
- Latency:
  - AW handshake at cycle N gives WREADY at N+1.
  - WLAST handshake at M gives BVALID at M+1.
  - BREADY handshake at K gives AWREADY at K+1.
- W beats presented before AW is accepted stall (WREADY=0).
- A new AWVALID is not accepted until the B handshake completes.

Read FSM (R_IDLE, R_DATA):
- R_IDLE: ARREADY=1. On ARVALID, latch ARID and ARLEN, clear the 4-bit beat counter, go to R_DATA.
- R_DATA: RVALID=1, RID=latched ARID, RDATA=0, RRESP=2'b11, RLAST=(counter==latched ARLEN).
  - On RREADY: if RLAST, go to R_IDLE; else counter increments.
  - Counter never wraps: ARLEN=15 gives 16 beats, RLAST on the 16th.
- RVALID is held high until each beat is accepted; payload is stable while RREADY=0.
- Latency: AR handshake at N gives the first RVALID at N+1; the last-beat handshake at K gives ARREADY at K+1.

Concurrency:
- Simultaneous AW and AR are both accepted in the same cycle.
- The read and write paths share no state.

Test Plan:
- Reset check: hold ARESETn=0, drive random inputs -> all outputs 0. After release -> AWREADY=1 and ARREADY=1 on the first clock.
- Write, 4 beats: AWID=8'h35, 4 W beats, WLAST on beat 4, BREADY=1 -> BVALID one cycle after WLAST, BID=8'h35, BRESP=2'b11, AWREADY back one cycle later.
- Read, ARLEN=3, ARID=8'h21, RREADY=1 -> exactly 4 beats, RDATA=0, RRESP=2'b11, RID=8'h21, RLAST only on beat 4.
- Backpressure, ARLEN=15, RREADY toggling 1-0-1-0 -> 16 beats, payload stable while stalled, no beat dropped or repeated; BREADY=0 for 5 cycles holds BVALID and BID.
- Concurrent traffic: AW (ID 8'h11) and AR (ID 8'h12, ARLEN=0) in the same cycle -> both accepted. Single R beat with RLAST=1 and RID=8'h12 at N+1; B with BID=8'h11 after WLAST.
- Reset mid-read at beat 2 of ARLEN=7 -> RVALID=0 immediately (asynchronous). After release, ARREADY=1 and a new ARLEN=0 read returns one beat.
